// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register ids and run-state encodings.
// Imported by every pipeline stage and by the control unit.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SADR = 3'd2;
   localparam logic [2:0] SINS = 3'd3;
   localparam logic [2:0] SHLT = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      RS_FLUSH  = 2'b00,
      RS_RUN    = 2'b01,
      RS_HALTED = 2'b10
   } runState_t;

   // Status 0 (bubble) and SAOK are both non-exceptional.
   function automatic logic isExc(input logic [2:0] stat);
      return (stat == SADR) || (stat == SINS) || (stat == SHLT);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
// One-cycle update latency; inc is ignored once saturated.
module sat_counter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         clrN,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge clrN) begin
      if (!clrN) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, flush/run/halt state machine, perf counters.
// Controls are combinational from stage fields in RUN; state, halt status and counters update per edge.
module pipe_hazard_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W        = 64,
   parameter int FLUSH_CYCLES = 3,
   parameter bit PERF_EN      = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [2:0]       m_stat,
   input  logic [3:0]       W_icode,
   input  logic [2:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic [1:0]       run_state,
   output logic             halted,
   output logic [2:0]       halt_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

   runState_t   state;
   logic [FW-1:0] flushCnt;

   logic loadUse;
   logic retHaz;
   logic misPred;
   logic excM;
   logic excW;

   assign loadUse = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign retHaz  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
   assign misPred = (E_icode == IJXX) && !e_Cnd;
   assign excM    = isExc(m_stat);
   assign excW    = isExc(W_stat);

   // Outside RUN/HALTED (flush and reset) the pipe is held at the ends and bubbled in the middle.
   always_comb begin
      F_stall  = 1'b1;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      case (state)
         RS_RUN: begin
            F_stall  = loadUse | retHaz;
            D_stall  = loadUse;
            D_bubble = misPred | (!loadUse & retHaz);
            E_bubble = misPred | loadUse;
            M_bubble = excM | excW;
            W_stall  = excW;
         end
         RS_HALTED: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b0;
            W_stall  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RS_FLUSH;
         flushCnt  <= FLUSH_INIT;
         halted    <= 1'b0;
         halt_stat <= 3'd0;
      end else begin
         case (state)
            RS_FLUSH: begin
               if (flushCnt == '0) begin
                  state <= RS_RUN;
               end else begin
                  flushCnt <= flushCnt - FW'(1);
               end
            end
            RS_RUN: begin
               if (excW) begin
                  state     <= RS_HALTED;
                  halted    <= 1'b1;
                  halt_stat <= W_stat;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign run_state = state;

   logic inRun;
   logic cycInc;
   logic retInc;
   logic bubInc;

   assign inRun  = (state == RS_RUN);
   assign cycInc = inRun;
   assign retInc = inRun && (W_stat == SAOK) && (W_icode != INOP) && !W_stall;
   // The halting cycle raises M_bubble, but it is accounted as a plain cycle only.
   assign bubInc = inRun && (D_bubble | E_bubble | M_bubble) && !excW;

   generate
      if (PERF_EN) begin : g_perf
         sat_counter #(.W(CNT_W)) u_cycCnt (
            .clk   (clk),
            .clrN  (rst_n),
            .inc   (cycInc),
            .count (cycle_cnt)
         );
         sat_counter #(.W(CNT_W)) u_retCnt (
            .clk   (clk),
            .clrN  (rst_n),
            .inc   (retInc),
            .count (retire_cnt)
         );
         sat_counter #(.W(CNT_W)) u_bubCnt (
            .clk   (clk),
            .clrN  (rst_n),
            .inc   (bubInc),
            .count (bubble_cnt)
         );
      end else begin : g_noPerf
         assign cycle_cnt  = '0;
         assign retire_cnt = '0;
         assign bubble_cnt = '0;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: flush sequencing, hazard controls, halt, counters and saturation.
module tb_pipe_hazard_ctrl;
   import y86_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
   logic e_Cnd;
   logic [2:0] m_stat, W_stat;

   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
   logic [1:0] run_state;
   logic [2:0] halt_stat;
   logic [63:0] cycle_cnt, retire_cnt, bubble_cnt;

   logic sF_stall, sD_stall, sD_bubble, sE_bubble, sM_bubble, sW_stall, sHalted;
   logic [1:0] sRunState;
   logic [2:0] sHaltStat;
   logic [3:0] sCycleCnt, sRetireCnt, sBubbleCnt;

   int errors = 0;
   int checks = 0;
   logic [63:0] expCyc, expRet, expBub;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(64), .FLUSH_CYCLES(3), .PERF_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .M_bubble(M_bubble), .W_stall(W_stall), .run_state(run_state), .halted(halted),
      .halt_stat(halt_stat), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4), .FLUSH_CYCLES(3), .PERF_EN(1'b1)) dutSmall (
      .clk(clk), .rst_n(rst_n),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
      .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
      .F_stall(sF_stall), .D_stall(sD_stall), .D_bubble(sD_bubble), .E_bubble(sE_bubble),
      .M_bubble(sM_bubble), .W_stall(sW_stall), .run_state(sRunState), .halted(sHalted),
      .halt_stat(sHaltStat), .cycle_cnt(sCycleCnt), .retire_cnt(sRetireCnt), .bubble_cnt(sBubbleCnt)
   );

   task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic setIdle();
      D_icode = INOP;  d_srcA = RNONE; d_srcB = RNONE;
      E_icode = INOP;  E_dstM = RNONE; e_Cnd = 1'b1;
      M_icode = INOP;  m_stat = SAOK;
      W_icode = INOP;  W_stat = SAOK;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic [5:0] ctlVec();
      return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
   endfunction

   // Apply one hazard pattern for part of a RUN cycle, check {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall}, then idle through the edge.
   task automatic hazVec(input string tag, input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] ei, input logic [3:0] edm, input logic cnd,
                         input logic [3:0] mi, input logic [2:0] ms, input logic [5:0] exp);
      D_icode = di; d_srcA = sa; d_srcB = sb;
      E_icode = ei; E_dstM = edm; e_Cnd = cnd;
      M_icode = mi; m_stat = ms;
      #1;
      checkVal(tag, {58'd0, ctlVec()}, {58'd0, exp});
      setIdle();
      step(1);
      expCyc = expCyc + 1;
   endtask

   initial begin
      setIdle();
      rst_n = 1'b0;
      #12;
      checkVal("rst_ctl", {58'd0, ctlVec()}, {58'd0, 6'b101111});
      checkVal("rst_state", {62'd0, run_state}, {62'd0, RS_FLUSH});
      checkVal("rst_halted", {63'd0, halted}, 64'd0);
      checkVal("rst_haltstat", {61'd0, halt_stat}, 64'd0);
      checkVal("rst_cycle", cycle_cnt, 64'd0);

      rst_n = 1'b1;
      step(2);
      checkVal("flush_state", {62'd0, run_state}, {62'd0, RS_FLUSH});
      checkVal("flush_ctl", {58'd0, ctlVec()}, {58'd0, 6'b101111});
      step(1);
      checkVal("run_state", {62'd0, run_state}, {62'd0, RS_RUN});
      checkVal("run_cycle0", cycle_cnt, 64'd0);
      checkVal("run_bubble0", bubble_cnt, 64'd0);
      checkVal("small_state", {62'd0, sRunState}, {62'd0, RS_RUN});

      W_icode = IOPQ;
      step(20);
      checkVal("cnt_cycle20", cycle_cnt, 64'd20);
      checkVal("cnt_retire20", retire_cnt, 64'd20);
      checkVal("sat_cycle", {60'd0, sCycleCnt}, 64'd15);
      checkVal("sat_retire", {60'd0, sRetireCnt}, 64'd15);
      step(3);
      checkVal("sat_cycle_hold", {60'd0, sCycleCnt}, 64'd15);
      checkVal("sat_retire_hold", {60'd0, sRetireCnt}, 64'd15);
      checkVal("sat_bubble", {60'd0, sBubbleCnt}, 64'd0);
      checkVal("small_ctl", {58'd0, sF_stall, sD_stall, sD_bubble, sE_bubble, sM_bubble, sW_stall}, 64'd0);
      checkVal("small_halt", {60'd0, sHalted, sHaltStat}, 64'd0);
      expCyc = 64'd23; expRet = 64'd23; expBub = 64'd0;
      W_icode = INOP;

      hazVec("lu_srcB",   INOP, RNONE, 4'd2, IMRMOVQ, 4'd2,  1'b1, INOP, SAOK, 6'b110100);
      hazVec("lu_popA",   INOP, 4'd3, RNONE, IPOPQ,   4'd3,  1'b1, INOP, SAOK, 6'b110100);
      hazVec("lu_rnone",  INOP, RNONE, RNONE, IMRMOVQ, RNONE, 1'b1, INOP, SAOK, 6'b000000);
      hazVec("mp_ret",    IRET, RNONE, RNONE, IJXX,    RNONE, 1'b0, INOP, SAOK, 6'b101100);
      hazVec("lu_ret",    IRET, RNONE, 4'd2, IMRMOVQ, 4'd2,  1'b1, INOP, SAOK, 6'b110100);
      hazVec("ret_m",     INOP, RNONE, RNONE, INOP,    RNONE, 1'b1, IRET, SAOK, 6'b101000);
      hazVec("jxx_taken", INOP, RNONE, RNONE, IJXX,    RNONE, 1'b1, INOP, SAOK, 6'b000000);
      hazVec("m_sadr",    INOP, RNONE, RNONE, INOP,    RNONE, 1'b1, INOP, SADR, 6'b000010);

      E_icode = IMRMOVQ; E_dstM = 4'd5; d_srcA = 4'd5;
      step(1);
      expCyc = expCyc + 1; expBub = expBub + 1;
      setIdle();
      checkVal("bub_cycle", cycle_cnt, expCyc);
      checkVal("bub_retire", retire_cnt, expRet);
      checkVal("bub_bubble", bubble_cnt, expBub);

      W_stat = SHLT; W_icode = IHALT;
      #1;
      checkVal("halt_pre_ctl", {58'd0, ctlVec()}, {58'd0, 6'b000011});
      step(1);
      expCyc = expCyc + 1;
      checkVal("halt_state", {62'd0, run_state}, {62'd0, RS_HALTED});
      checkVal("halt_flag", {63'd0, halted}, 64'd1);
      checkVal("halt_stat", {61'd0, halt_stat}, 64'd4);
      checkVal("halt_ctl", {58'd0, ctlVec()}, {58'd0, 6'b110001});
      checkVal("halt_cycle", cycle_cnt, expCyc);
      checkVal("halt_bubble", bubble_cnt, expBub);

      W_stat = SAOK; W_icode = IOPQ; E_icode = IMRMOVQ; E_dstM = 4'd2; d_srcB = 4'd2;
      step(3);
      checkVal("frz_state", {62'd0, run_state}, {62'd0, RS_HALTED});
      checkVal("frz_haltstat", {61'd0, halt_stat}, 64'd4);
      checkVal("frz_cycle", cycle_cnt, expCyc);
      checkVal("frz_retire", retire_cnt, expRet);
      checkVal("frz_bubble", bubble_cnt, expBub);

      rst_n = 1'b0;
      #1;
      checkVal("hrst_state", {62'd0, run_state}, {62'd0, RS_FLUSH});
      checkVal("hrst_halt", {60'd0, halted, halt_stat}, 64'd0);
      checkVal("hrst_cycle", cycle_cnt, 64'd0);
      checkVal("hrst_ctl", {58'd0, ctlVec()}, {58'd0, 6'b101111});
      setIdle();
      #3;
      rst_n = 1'b1;
      step(3);
      checkVal("rerun_state", {62'd0, run_state}, {62'd0, RS_RUN});
      W_icode = IOPQ;
      step(2);
      checkVal("rerun_retire", retire_cnt, 64'd2);
      rst_n = 1'b0;
      #1;
      checkVal("rrst_cycle", cycle_cnt, 64'd0);
      checkVal("rrst_state", {62'd0, run_state}, {62'd0, RS_FLUSH});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
